// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and baud tick divider.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
    } rx_state_t;
`endif

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned rate;
        int unsigned div;
        rate = baud * oversample;
        div  = (clk_freq + rate / 2) / rate;
        return (div == 0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count for full/empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push overwrites.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver with FWFT receive FIFO and error pulses.
// Parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_gen #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 full,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    import uart_pkg::*;

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TW   = $clog2(DIV + 1);
    localparam int unsigned OSW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW   = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF = OVERSAMPLE / 2;

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_bad;
    logic                 counting;
    logic                 half_pt;
    logic                 full_pt;
    logic                 last_data;
    logic                 last_stop;
    logic                 stop_done;
    logic                 frame_bad;
    logic                 par_bad;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign counting  = (state != ST_IDLE) && (state != ST_WAIT_IDLE);
    assign tick      = counting && (tick_cnt == TW'(DIV - 1));
    assign half_pt   = tick && (state == ST_START) && (os_cnt == OSW'(HALF - 1));
    assign full_pt   = tick && (state != ST_START) && (os_cnt == OSW'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
    assign stop_done = (state == ST_STOP) && full_pt && last_stop;
    assign frame_bad = stop_bad || !rx_s;

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == ST_PARITY && full_pt) begin
            par_bit <= rx_s;
        end
    end

    assign par_bad = (^{shreg, par_bit}) ^ PARITY_ODD;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_nxt = ST_START;
            ST_START:     if (half_pt) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      if (full_pt && last_data) state_nxt = ST_PARITY;
            ST_PARITY:    if (full_pt) state_nxt = ST_STOP;
`else
            ST_DATA:      if (full_pt && last_data) state_nxt = ST_STOP;
`endif
            ST_STOP:      if (stop_done) state_nxt = frame_bad ? ST_WAIT_IDLE : ST_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are masked by rst so a frame cut short by reset leaves no trace.
    always_comb begin
        push       = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        if (stop_done && !rst) begin
            push      = !frame_bad && !par_bad;
            frame_err = frame_bad;
`ifdef UART_RX_PARITY_EN
            parity_err = par_bad;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !counting) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                os_cnt <= (half_pt || full_pt) ? '0 : os_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != state_nxt) begin
            bit_cnt <= '0;
        end else if (full_pt) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (state == ST_DATA && full_pt) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_STOP) begin
            stop_bad <= 1'b0;
        end else if (full_pt && !rx_s) begin
            stop_bad <= 1'b1;
        end
    end

    assign pop     = rd_en && !fifo_empty;
    assign overrun = push && fifo_full && !pop;
    assign valid   = !fifo_empty;
    assign full    = fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_gen.sv
// Scoreboard bench for uart_rx_gen: stimulus queues expected words, a monitor
// checks every pop and counts flag pulses.
`timescale 1ns/1ps
module tb_uart_rx_gen;

    localparam int BIT_NS = 8680;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_perr   = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always #10 clk = ~clk;

    uart_rx_gen #(
        .CLK_FREQ   (50000000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD (1'b0)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_en      (rd_en),
        .data       (data),
        .valid      (valid),
        .full       (full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int jit);
        rx = 1'b0;
        #(BIT_NS + jit);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS + ((i % 2 == 0) ? -jit : jit));
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        #(BIT_NS);
`endif
        rx = stop_val;
        #(BIT_NS);
    endtask

    task automatic pop_one();
        int n = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pop_valid", valid, 1);
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    // Monitor: count flag pulses and score every accepted pop.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (parity_err) n_perr++;
            if (rd_en && valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", data);
                end else begin
                    check("pop_data", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #4000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_full", full, 0);
        check("rst_data", data, 0);
        check("rst_flags", {frame_err, overrun, parity_err}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_valid", valid, 0);

        // Single frame, then two jittered frames back to back with no reads.
        exp_q.push_back(8'h59);
        send_frame(8'h59, 1'b1, 0);
        @(negedge clk);
        check("f1_valid", valid, 1);
        check("f1_data", data, 8'h59);
        check("f1_flags", n_ferr + n_ovr + n_perr, 0);
        exp_q.push_back(8'hBA);
        send_frame(8'hBA, 1'b1, 4);
        exp_q.push_back(8'hBF);
        send_frame(8'hBF, 1'b1, 4);
        @(negedge clk);
        check("f3_full", full, 0);
        check("f3_head", data, 8'h59);

        // Fill to depth, then overrun on the fifth word.
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0);
        @(negedge clk);
        check("f4_full", full, 1);
        send_frame(8'hC5, 1'b1, 0);
        @(negedge clk);
        check("ovr_count", n_ovr, 1);
        check("ovr_full", full, 1);
        check("ovr_head", data, 8'h59);
        repeat (4) pop_one();
        @(negedge clk);
        check("drain_valid", valid, 0);
        check("drain_full", full, 0);

        // Read request on an empty FIFO is ignored.
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
        check("empty_rd_valid", valid, 0);
        check("empty_rd_data", data, 0);

        // Stop bit low, line held low afterwards, then a clean frame.
        send_frame(8'h59, 1'b0, 0);
        rx = 1'b0;
        #(2 * BIT_NS);
        rx = 1'b1;
        #(10 * BIT_NS);
        @(negedge clk);
        check("ferr_count", n_ferr, 1);
        check("ferr_no_push", valid, 0);
        exp_q.push_back(8'hBA);
        send_frame(8'hBA, 1'b1, 0);
        pop_one();

        // Short glitch on the idle line.
        rx = 1'b0;
        #2000;
        rx = 1'b1;
        #(3 * BIT_NS);
        @(negedge clk);
        check("glitch_valid", valid, 0);
        check("glitch_ferr", n_ferr, 1);
        check("glitch_ovr", n_ovr, 1);

        // Reset in the middle of a frame.
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
        rx = 1'b0;
        #(2 * BIT_NS);
        @(posedge clk); #1 rst = 1'b1; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", valid, 0);
        #(10 * BIT_NS);
        @(negedge clk);
        check("midrst_valid_late", valid, 0);
        check("midrst_ferr", n_ferr, 1);
        check("midrst_ovr", n_ovr, 1);
        exp_q.push_back(8'hBF);
        send_frame(8'hBF, 1'b1, 0);
        pop_one();

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h59, 1'b1, 0);
        par_flip = 1'b0;
        @(negedge clk);
        check("perr_count", n_perr, 1);
        check("perr_no_push", valid, 0);
        exp_q.push_back(8'h59);
        send_frame(8'h59, 1'b1, 0);
        pop_one();
        repeat (5) @(negedge clk);
        check("final_perr", n_perr, 1);
`else
        repeat (5) @(negedge clk);
        check("final_perr", n_perr, 0);
`endif
        check("final_valid", valid, 0);
        check("final_ferr", n_ferr, 1);
        check("final_ovr", n_ovr, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit; even, range 8..32.
REQ-004 Parameter DATA_BITS, default 8, data bits per frame; range 5..9.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame; range 1..2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive FIFO depth in words; power of two, at least 2.
REQ-007 Port clk, input, 1, system clock; single clock domain.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port rx, input, 1, asynchronous serial line; idle high.
REQ-010 Port rd_en, input, 1, pop request for the FIFO head.
REQ-011 Port data, output, DATA_BITS, FIFO head word, valid only while valid=1.
REQ-012 Port valid, output, 1, FIFO not empty.
REQ-013 Port full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-014 Port frame_err, output, 1, one-cycle pulse when a stop bit samples low.
REQ-015 Port overrun, output, 1, one-cycle pulse when a good word is dropped because the FIFO is full.
REQ-016 Port parity_err, output, 1, one-cycle pulse on parity mismatch; tied to 0 when the parity feature is compiled out.

Function
REQ-017 rx shall pass through a two-flop synchroniser, reset to 1, before any use.
REQ-018 A tick counter shall assert a one-cycle tick every DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) cycles; it is held cleared while the FSM is in IDLE.
REQ-019 FSM states shall be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-020 IDLE->START shall occur on the first cycle the synchronised rx is 0.
REQ-021 In START, at OVERSAMPLE/2 ticks: rx=0 goes to DATA; rx=1 goes back to IDLE as a glitch, with no word and no flag.
REQ-022 In DATA, one bit shall be sampled every OVERSAMPLE ticks, LSB first, DATA_BITS times.
REQ-023 After DATA, the FSM shall go to PARITY if the feature is enabled, otherwise to STOP.
REQ-024 STOP shall sample STOP_BITS bits at OVERSAMPLE-tick spacing; any low sample shall set frame_err.
REQ-025 A frame with no error shall be pushed on the cycle of the last stop sample.
REQ-026 A frame with a frame or parity error shall be discarded and its error pulse asserted on that same cycle.
REQ-027 After a frame error, the FSM shall enter WAIT_IDLE and stay until rx=1; all other frames return to IDLE.
REQ-028 The FIFO shall be first-word-fall-through; data/valid shall update the cycle after a push into an empty FIFO (push-to-valid latency 1).
REQ-029 A pop shall occur only when rd_en=1 and valid=1; rd_en while empty shall be ignored.
REQ-030 A push while full with no pop shall drop the word and pulse overrun; FIFO contents are unchanged.
REQ-031 A push and pop in the same cycle shall both take effect, including when full (no overrun); occupancy is unchanged.
REQ-032 Read and write pointers shall be log2(FIFO_DEPTH) bits wide, wrap modulo FIFO_DEPTH, and use an extra occupancy bit for full/empty.

Reset
REQ-033 On rst: FSM to IDLE, FIFO emptied, synchroniser to 1, tick and bit counters to 0.
REQ-034 Output reset values: data=0, valid=0, full=0, frame_err=0, overrun=0, parity_err=0.
REQ-035 Reset asserted mid-frame shall abort the frame with no push and no flag pulse.

Configuration
REQ-036 Macro UART_RX_PARITY_EN defined: parameter PARITY_ODD (default 0, even parity) is added, the PARITY state samples one bit, and a mismatch discards the word and pulses parity_err.
REQ-037 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame = start + DATA_BITS + STOP_BITS, and parity_err is constant 0.

Structure
REQ-038 Shared package uart_pkg shall hold the FSM state encoding and a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
REQ-039 The FIFO shall be a sub-module sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/full/empty.

Verification
REQ-040 Defaults, parity off; rx sends bits 1,0,0,1,1,0,1,0 LSB first with 8680 ns bit time -> valid rises, data=0x59, no flags.
REQ-041 Three back-to-back frames 0x59, 0xBA, 0xBF with ±4 ns bit jitter, no reads -> valid=1, then pops return 0x59, 0xBA, 0xBF in order, then valid=0.
REQ-042 Five frames with rd_en=0 and FIFO_DEPTH=4 -> full=1 after the fourth, overrun pulses once on the fifth, and the head is still the first word.
REQ-043 Stop bit driven 0 on frame 0x59 -> frame_err pulses once, no push, FSM holds WAIT_IDLE until rx=1, and the next frame 0xBA is received correctly.
REQ-044 A 2 us low glitch on an idle line -> no push, no flags, FSM returns to IDLE; rst pulsed mid-frame -> valid=0, no flags, next frame received correctly.
REQ-045 UART_RX_PARITY_EN defined, even parity; 0x59 sent with parity bit 1 -> parity_err pulses once and no push; resent with parity 0 -> data=0x59.
